// File: rtl/sram_array_1r1w_ext.sv
// One-read/one-write SRAM array model with segment write masks, read-data hold,
// optional write-to-read bypass, optional output register and post-reset clear.
module sram_array_1r1w_ext #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned MASK_W     = 2,
  parameter int unsigned PIPE_OUT   = 0,
  parameter int unsigned BYPASS     = 0,
  parameter int unsigned RESET_INIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  output logic              init_done
);

  localparam int unsigned SEG_W = DATA_W / MASK_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rdy;
  logic              r_fire;
  logic              w_fire;
  logic              r_in;
  logic              w_in;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] rd_word;

  logic              resp_v1_q;
  logic [DATA_W-1:0] resp_d1_q;

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int s = 0; s < int'(MASK_W); s++) begin
      if (mask[s]) res[s*SEG_W +: SEG_W] = new_w[s*SEG_W +: SEG_W];
    end
    return res;
  endfunction

  assign rdy       = (state_q == ST_READY);
  assign r_ready   = rdy;
  assign w_ready   = rdy;
  assign init_done = rdy;

  // Nothing fires on a reset edge so the restarted clear sees untouched memory.
  assign r_fire = r_valid & rdy & ~reset;
  assign w_fire = w_valid & rdy & ~reset;
  assign r_in   = ({1'b0, r_addr} < DEPTH_A);
  assign w_in   = ({1'b0, w_addr} < DEPTH_A);
  assign r_idx  = r_addr[IDX_W-1:0];
  assign w_idx  = w_addr[IDX_W-1:0];
  assign w_word = merge_word(mem_q[w_idx], w_data, w_mask);

  // Read word: zero when out of range, post-write word on a bypassed collision.
  always_comb begin
    rd_word = '0;
    if (r_in) begin
      rd_word = mem_q[r_idx];
      if ((BYPASS != 0) && w_fire && w_in && (w_addr == r_addr)) rd_word = w_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (RESET_INIT == 0) begin
            state_q <= ST_READY;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) state_q <= ST_READY;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (state_q == ST_INIT) && (RESET_INIT != 0)) begin
      mem_q[cnt_q] <= '0;
    end else if (w_fire && w_in) begin
      mem_q[w_idx] <= w_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_v1_q <= 1'b0;
      resp_d1_q <= '0;
    end else begin
      resp_v1_q <= r_fire;
      if (r_fire) resp_d1_q <= rd_word;
    end
  end

  if (PIPE_OUT != 0) begin : g_pipe
    logic              resp_v2_q;
    logic [DATA_W-1:0] resp_d2_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        resp_v2_q <= 1'b0;
        resp_d2_q <= '0;
      end else begin
        resp_v2_q <= resp_v1_q;
        if (resp_v1_q) resp_d2_q <= resp_d1_q;
      end
    end

    assign r_resp_valid = resp_v2_q;
    assign r_resp_data  = resp_d2_q;
  end else begin : g_nopipe
    assign r_resp_valid = resp_v1_q;
    assign r_resp_data  = resp_d1_q;
  end

endmodule

// File: tb/tb_sram_array_1r1w_ext.sv
// Directed bench: dut0 is the default build, dut1 adds bypass and the output stage.
module tb_sram_array_1r1w_ext;

  localparam int AW = 6;
  localparam int DW = 20;
  localparam int MW = 2;
  localparam int NV = 26;

  logic          clock;
  logic          reset;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic          w_valid;
  logic [AW-1:0] w_addr;
  logic [MW-1:0] w_mask;
  logic [DW-1:0] w_data;

  logic          rr0, wr0, rv0, id0;
  logic [DW-1:0] rd0;
  logic          rr1, wr1, rv1, id1;
  logic [DW-1:0] rd1;

  int n_chk = 0;
  int n_err = 0;

  sram_array_1r1w_ext #(.DEPTH(32), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                        .PIPE_OUT(0), .BYPASS(0), .RESET_INIT(1)) dut0 (
    .clock(clock), .reset(reset),
    .r_valid(r_valid), .r_ready(rr0), .r_addr(r_addr),
    .r_resp_valid(rv0), .r_resp_data(rd0),
    .w_valid(w_valid), .w_ready(wr0), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .init_done(id0)
  );

  sram_array_1r1w_ext #(.DEPTH(32), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                        .PIPE_OUT(1), .BYPASS(1), .RESET_INIT(1)) dut1 (
    .clock(clock), .reset(reset),
    .r_valid(r_valid), .r_ready(rr1), .r_addr(r_addr),
    .r_resp_valid(rv1), .r_resp_data(rd1),
    .w_valid(w_valid), .w_ready(wr1), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .init_done(id1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [MW-1:0] wm;
    logic [DW-1:0] wd;
    logic          rv;
    logic [AW-1:0] ra;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic wv, input int wa, input int wm, input int wd,
                              input logic rv, input int ra, input int e0, input int e1);
    vec_t v;
    v.wv = wv; v.wa = AW'(wa); v.wm = MW'(wm); v.wd = DW'(wd);
    v.rv = rv; v.ra = AW'(ra); v.e0 = DW'(e0); v.e1 = DW'(e1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    r_valid = 1'b0; r_addr = '0;
    w_valid = 1'b0; w_addr = '0; w_mask = '0; w_data = '0;
  endtask

  task automatic wait_init(input string nm, output int cyc, output int stray);
    cyc = 0;
    stray = 0;
    while (!id0 && cyc < 100) begin
      tick();
      cyc++;
      if (rv0 || rv1) stray++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'd32);
    chk({nm, "_done1"}, {31'd0, id1}, 32'd1);
  endtask

  initial begin
    int cyc;
    int stray;

    // e0: dut0 response data, e1: dut1 response data (held value when no read)
    vt[0]  = mk(0,  0, 0, 0,       1,  0, 'h00000, 'h00000);
    vt[1]  = mk(0,  0, 0, 0,       1, 31, 'h00000, 'h00000);
    vt[2]  = mk(1,  5, 3, 'hABCDE, 0,  0, 'h00000, 'h00000);
    vt[3]  = mk(1,  5, 1, 'h12345, 0,  0, 'h00000, 'h00000);
    vt[4]  = mk(0,  0, 0, 0,       1,  5, 'hABF45, 'hABF45);
    vt[5]  = mk(1,  5, 3, 'hFFFFF, 0,  0, 'hABF45, 'hABF45);
    vt[6]  = mk(0,  0, 0, 0,       1,  5, 'hFFFFF, 'hFFFFF);
    vt[7]  = mk(0,  0, 0, 0,       0,  0, 'hFFFFF, 'hFFFFF);
    vt[8]  = mk(1,  7, 1, 'h003FF, 1,  7, 'h00000, 'h003FF);
    vt[9]  = mk(0,  0, 0, 0,       1,  7, 'h003FF, 'h003FF);
    vt[10] = mk(1,  7, 0, 'h55555, 1,  6, 'h00000, 'h00000);
    vt[11] = mk(0,  0, 0, 0,       1,  7, 'h003FF, 'h003FF);
    vt[12] = mk(1, 40, 3, 'hFFFFF, 0,  0, 'h003FF, 'h003FF);
    vt[13] = mk(0,  0, 0, 0,       1, 40, 'h00000, 'h00000);
    vt[14] = mk(0,  0, 0, 0,       1,  8, 'h00000, 'h00000);
    vt[15] = mk(1,  1, 3, 'h11111, 0,  0, 'h00000, 'h00000);
    vt[16] = mk(1,  2, 3, 'h22222, 1,  1, 'h11111, 'h11111);
    vt[17] = mk(1,  3, 3, 'h33333, 1,  2, 'h22222, 'h22222);
    vt[18] = mk(0,  0, 0, 0,       1,  3, 'h33333, 'h33333);
    vt[19] = mk(0,  0, 0, 0,       1,  0, 'h00000, 'h00000);
    vt[20] = mk(0,  0, 0, 0,       1,  1, 'h11111, 'h11111);
    vt[21] = mk(0,  0, 0, 0,       1,  2, 'h22222, 'h22222);
    vt[22] = mk(0,  0, 0, 0,       1,  3, 'h33333, 'h33333);
    vt[23] = mk(0,  0, 0, 0,       0,  0, 'h33333, 'h33333);
    vt[24] = mk(1,  1, 2, 'hFFFFF, 1,  1, 'h11111, 'hFFD11);
    vt[25] = mk(0,  0, 0, 0,       1,  1, 'hFFD11, 'hFFD11);

    idle();
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_outs0", {27'd0, rr0, wr0, id0, rv0, 1'b0}, 32'd0);
    chk("reset_outs1", {27'd0, rr1, wr1, id1, rv1, 1'b0}, 32'd0);
    chk("reset_data0", 32'(rd0), 32'd0);
    chk("reset_data1", 32'(rd1), 32'd0);

    // Requests during the clear must be ignored; addr 0 is already cleared by then.
    reset = 1'b0;
    r_valid = 1'b1; r_addr = '0;
    w_valid = 1'b1; w_addr = '0; w_mask = 2'b11; w_data = 20'hFFFFF;
    stray = 0;
    repeat (10) begin
      tick();
      if (rv0 || rv1 || id0 || id1) stray++;
    end
    chk("bp_first_clear", 32'(stray), 32'd0);

    reset = 1'b1;
    tick();
    chk("midclear_reset", {29'd0, id0, rv0, rv1}, 32'd0);
    reset = 1'b0;
    wait_init("init", cyc, stray);
    idle();
    chk("bp_no_resp", 32'(stray), 32'd0);

    for (int i = 0; i < NV; i++) begin
      w_valid = vt[i].wv; w_addr = vt[i].wa; w_mask = vt[i].wm; w_data = vt[i].wd;
      r_valid = vt[i].rv; r_addr = vt[i].ra;
      tick();
      chk($sformatf("v%0d_valid0", i), {31'd0, rv0}, {31'd0, vt[i].rv});
      chk($sformatf("v%0d_data0", i), 32'(rd0), 32'(vt[i].e0));
      if (i == 0) begin
        chk("v0_valid1", {31'd0, rv1}, 32'd0);
        chk("v0_data1", 32'(rd1), 32'd0);
      end else begin
        chk($sformatf("v%0d_valid1", i - 1), {31'd0, rv1}, {31'd0, vt[i-1].rv});
        chk($sformatf("v%0d_data1", i - 1), 32'(rd1), 32'(vt[i-1].e1));
      end
    end
    idle();
    tick();
    chk("tail_valid0", {31'd0, rv0}, 32'd0);
    chk("tail_valid1", {31'd0, rv1}, 32'd1);
    chk("tail_data1", 32'(rd1), 32'(vt[NV-1].e1));

    // Reset with dut1's response still in its output stage: squashed.
    r_valid = 1'b1; r_addr = 6'd1;
    tick();
    chk("preabort_valid0", {31'd0, rv0}, 32'd1);
    chk("preabort_data0", 32'(rd0), 32'hFFD11);
    r_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_valid", {30'd0, rv0, rv1}, 32'd0);
    chk("abort_data0", 32'(rd0), 32'd0);
    chk("abort_data1", 32'(rd1), 32'd0);
    reset = 1'b0;
    wait_init("reinit", cyc, stray);
    chk("reinit_no_resp", 32'(stray), 32'd0);

    // After the restarted clear, addr 1 must read zero again.
    w_valid = 1'b1; w_addr = 6'd2; w_mask = 2'b11; w_data = 20'h12345;
    tick();
    idle();
    r_valid = 1'b1; r_addr = 6'd2;
    tick();
    chk("reinit_rd2_d0", 32'(rd0), 32'h12345);
    r_addr = 6'd1;
    tick();
    chk("reinit_rd1_d0", 32'(rd0), 32'd0);
    chk("reinit_rd2_d1", 32'(rd1), 32'h12345);
    idle();
    tick();
    chk("reinit_rd1_d1", 32'(rd1), 32'd0);
    chk("reinit_rd1_v1", {31'd0, rv1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
